gate_vector_checker: RTL
========================

GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 The block SHALL have one parameter: HOLD_CYCLES, default 4, number of clock cycles each input vector is held (legal range 2..255).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  run request, sampled in IDLE only.
REQ-005 a_o  output  1  operand a driven to the gate block under test.
REQ-006 b_o  output  1  operand b driven to the gate block under test.
REQ-007 y_i  input  3  gate block response: y_i[2]=AND, y_i[1]=OR, y_i[0]=NOT a.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  one-cycle pulse at the end of a run.
REQ-010 pass  output  1  run verdict, valid from done until the next start is accepted.
REQ-011 err_cnt  output  3  number of failing vectors in the last run (0..4).
REQ-012 fail_vec  output  4  bit i set when vector i failed; vector index i = {a,b}.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, CHECK and DONE.
REQ-014 In IDLE, start=1 SHALL do the following on the next edge:
- clear err_cnt, fail_vec and pass;
- set the vector index to 0;
- enter DRIVE with busy=1.
REQ-015 Vectors SHALL be applied in order {a_o,b_o} = 00, 01, 10, 11, with a_o/b_o registered and changing only when a new vector begins.
REQ-016 Each vector SHALL be held exactly HOLD_CYCLES cycles: HOLD_CYCLES-1 cycles in DRIVE (hold counter down to 1), then one cycle in CHECK.
REQ-017 In CHECK, y_i SHALL be compared against the expected value {a&b, a|b, ~a}.
REQ-018 On any bit mismatch in CHECK, err_cnt SHALL increment by 1 and fail_vec[index] SHALL be set.
REQ-019 After CHECK, the next state SHALL be:
- vector index < 3: increment the index and return to DRIVE;
- vector index = 3: enter DONE.
REQ-020 DONE SHALL last one cycle, with done=1, pass=(err_cnt==0) and busy=0 on the following edge, then return to IDLE.
REQ-021 With start accepted at edge k, done SHALL be high in the cycle starting at edge k+1+4*HOLD_CYCLES (k+17 for HOLD_CYCLES=4).
REQ-022 start SHALL be ignored while busy=1 or in DONE; there is no queuing.
REQ-023 start held high continuously SHALL begin a new run on the first IDLE cycle after DONE.
REQ-024 pass, err_cnt and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-025 err_cnt SHALL never wrap; its maximum value is 4.
REQ-026 y_i SHALL be sampled only in CHECK; values in DRIVE are don't-care (settling time).

Reset
REQ-027 rst_n=0 SHALL immediately force the following, regardless of the current state:
- state IDLE;
- a_o=0, b_o=0;
- busy=0, done=0, pass=0;
- err_cnt=0, fail_vec=0;
- hold counter and vector index = 0.
REQ-028 Reset mid-run SHALL abort the run with no done pulse; a fresh start after rst_n=1 SHALL run all four vectors.

Structure
REQ-029 A shared package gate_chk_pkg SHALL hold:
- the state enum;
- NUM_VECTORS=4;
- the response width constant 3.
REQ-030 The expected-response function SHALL be a combinational sub-module gate_ref (inputs a, b; output exp_y[2:0]), instantiated once.
REQ-031 The hold counter width SHALL be 8 bits.

Verification
REQ-032 Correct gate block looped back, HOLD_CYCLES=4, start pulse at edge k -> a_o/b_o step 00,01,10,11 every 4 cycles; done at k+17; pass=1, err_cnt=0, fail_vec=0000.
REQ-033 AND output stuck at 0 -> err_cnt=1, fail_vec=1000, pass=0.
REQ-034 NOT output inverted (y_i[0]=a) -> err_cnt=4, fail_vec=1111, pass=0.
REQ-035 start pulsed again mid-run (after vector 1) -> ignored; done occurs at the original cycle; results match a single run.
REQ-036 rst_n asserted during vector 2 -> all outputs 0 immediately; no done pulse; a new start gives a complete correct run with pass=1.
REQ-037 Failing run followed by a passing run -> err_cnt/fail_vec clear on the second start; final pass=1, err_cnt=0.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the two-input gate vector checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int RESP_W      = 3;
  localparam int CNT_W       = 8;
  localparam int VEC_IDX_W   = 2;

endpackage

// File: rtl/gate_ref.sv
// Golden response of the gate block: {AND, OR, NOT a}.
module gate_ref
  import gate_chk_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [RESP_W-1:0] exp_y
);

  assign exp_y = {a & b, a | b, ~a};

endmodule

// File: rtl/gate_vector_checker.sv
// Walks {a,b} through 00..11, holds each vector HOLD_CYCLES cycles, and
// checks the gate block response once per vector just before moving on.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              a_o,
  output logic              b_o,
  input  logic [RESP_W-1:0] y_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2:0]        err_cnt,
  output logic [3:0]        fail_vec,
  output state_t            state_dbg
);

  // Handshake: start is a level request, taken only on an IDLE cycle;
  // done is a single-cycle pulse and the verdict stays put until the next run.

  localparam logic [CNT_W-1:0]     HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_IDX_W-1:0] LAST_VEC  = VEC_IDX_W'(NUM_VECTORS - 1);
  localparam logic [2:0]           ERR_MAX   = 3'(NUM_VECTORS);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      hold_q;
  logic [VEC_IDX_W-1:0]  idx_q;
  logic [VEC_IDX_W-1:0]  idx_next;
  logic [RESP_W-1:0]     exp_y;

  logic accept;
  logic hold_dec;
  logic mismatch;
  logic next_vec;
  logic finish;

  gate_ref u_gate_ref (
    .a     (a_o),
    .b     (b_o),
    .exp_y (exp_y)
  );

  assign idx_next  = idx_q + VEC_IDX_W'(1);
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_DRIVE;
      ST_DRIVE: if (hold_q <= CNT_W'(1)) state_d = ST_CHECK;
      ST_CHECK: state_d = (idx_q == LAST_VEC) ? ST_DONE : ST_DRIVE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept   = (state_q == ST_IDLE) && start;
    hold_dec = (state_q == ST_DRIVE) && (hold_q > CNT_W'(1));
    mismatch = (state_q == ST_CHECK) && (y_i != exp_y);
    next_vec = (state_q == ST_CHECK) && (idx_q != LAST_VEC);
    finish   = (state_q == ST_DONE);
  end

  // The response is only looked at in CHECK; DRIVE cycles give it time to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o      <= 1'b0;
      b_o      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
      hold_q   <= '0;
      idx_q    <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        err_cnt  <= '0;
        fail_vec <= '0;
        pass     <= 1'b0;
        idx_q    <= '0;
        a_o      <= 1'b0;
        b_o      <= 1'b0;
        hold_q   <= HOLD_LOAD;
        busy     <= 1'b1;
      end
      if (hold_dec) hold_q <= hold_q - CNT_W'(1);
      if (mismatch) begin
        if (err_cnt < ERR_MAX) err_cnt <= err_cnt + 3'd1;
        fail_vec[idx_q] <= 1'b1;
      end
      if (next_vec) begin
        idx_q  <= idx_next;
        a_o    <= idx_next[1];
        b_o    <= idx_next[0];
        hold_q <= HOLD_LOAD;
      end
      if (finish) begin
        busy <= 1'b0;
        pass <= (err_cnt == 3'd0);
      end
    end
  end

endmodule
